// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: multiplier FSM states and ALU control codes
package cpu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational datapath ALU driven by the multiply sequencer
//
// Ports:
//   A, B       operands
//   cntrl      operation select (cpu_pkg ALU_* codes)
//   result     operation result
//   carry_out  carry of ADD, borrow of SUB, 0 otherwise
module alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    logic [WIDTH:0] wide;

    always_comb begin
        wide = '0;
        case (cntrl)
            ALU_PASS_B: wide = {1'b0, B};
            ALU_ADD:    wide = {1'b0, A} + {1'b0, B};
            ALU_SUB:    wide = {1'b0, A} - {1'b0, B};
            ALU_AND:    wide = {1'b0, A & B};
            ALU_OR:     wide = {1'b0, A | B};
            ALU_XOR:    wide = {1'b0, A ^ B};
            default:    wide = '0;
        endcase
    end

    assign result    = wide[WIDTH-1:0];
    assign carry_out = wide[WIDTH];

endmodule

// File: rtl/mul_counter.sv
// rtl/mul_counter.sv - iteration counter with clear/enable and terminal count
//
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   clr         synchronous clear to 0 (wins over en)
//   en          increment by one
//   cnt         current count
//   tc          count equals TERM
module mul_counter #(
    parameter int               CNT_W = 7,
    parameter logic [CNT_W-1:0] TERM  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == TERM);

endmodule

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-add multiplier sequencing an external ALU
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (mcand, mplier)
//   out_valid/out_ready   result handshake (product, negative, zero, high_nz)
//   alu_A/alu_B/alu_cntrl to external ALU (always ADD; A/B zero outside RUN)
//   alu_result/alu_carry  from external ALU
//
// Build option: MUL_EARLY_TERM_EN stops iterating once the remaining
// multiplier bits are all zero.
module alu_mul_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             negative,
    output logic             zero,
    output logic             high_nz,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0] mp_q, mp_d;
    logic             high_nz_q, high_nz_d;
    logic             mc_lost_q, mc_lost_d;
    logic             out_valid_q, out_valid_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt;

    mul_counter #(
        .CNT_W (CNT_W),
        .TERM  (LAST)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // mc_lost remembers that some multiplicand bit has already been shifted
    // past the top. Any later multiplier 1-bit would have weighted that bit
    // at or above 2^WIDTH, so the true product overflows.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mc_d        = mc_q;
        mp_d        = mp_q;
        high_nz_d   = high_nz_q;
        mc_lost_d   = mc_lost_q;
        out_valid_d = out_valid_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (in_valid) begin
                    mc_d      = mcand;
                    mp_d      = mplier;
                    acc_d     = '0;
                    high_nz_d = 1'b0;
                    mc_lost_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                cnt_en    = 1'b1;
                acc_d     = alu_result;
                mc_d      = mc_q << 1;
                mp_d      = mp_q >> 1;
                mc_lost_d = mc_lost_q | mc_q[WIDTH-1];
                if (alu_carry || (mp_q[0] && mc_lost_q)) begin
                    high_nz_d = 1'b1;
                end
`ifdef MUL_EARLY_TERM_EN
                if (cnt_tc || (mp_d == '0)) begin
                    state_d = DONE;
                end
`else
                if (cnt_tc) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mc_q        <= '0;
            mp_q        <= '0;
            high_nz_q   <= 1'b0;
            mc_lost_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mc_q        <= mc_d;
            mp_q        <= mp_d;
            high_nz_q   <= high_nz_d;
            mc_lost_q   <= mc_lost_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign product   = acc_q;
    assign negative  = acc_q[WIDTH-1];
    assign zero      = (acc_q == '0);
    assign high_nz   = high_nz_q;
    assign alu_cntrl = ALU_ADD;
    assign alu_A     = (state_q == RUN) ? acc_q : '0;
    assign alu_B     = ((state_q == RUN) && mp_q[0]) ? mc_q : '0;

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Iterative shift-add multiplier acting as the initiator of the datapath ALU port: it drives an external ALU's A/B/cntrl inputs and consumes its result/carry.
- Produces the low WIDTH bits of an unsigned product plus N/Z flags for the MUL instruction path.
- Sits beside the register-file read ports; valid/ready handshake on both sides.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  sequencer can accept operands.
- mcand  input  WIDTH  multiplicand.
- mplier  input  WIDTH  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  WIDTH  low WIDTH bits of mcand*mplier.
- negative  output  1  product[WIDTH-1].
- zero  output  1  product == 0.
- high_nz  output  1  discarded upper bits were non-zero (unsigned overflow).
- alu_A  output  WIDTH  to ALU A: current accumulator.
- alu_B  output  WIDTH  to ALU B: shifted multiplicand or 0.
- alu_cntrl  output  3  to ALU cntrl; constant 3'b010 (add).
- alu_result  input  WIDTH  from ALU result.
- alu_carry  input  1  from ALU carry_out.

Behaviour:
- Reset (reset==0, async): state=IDLE, acc=0, mc=0, mp=0, cnt=0, high_nz=0, out_valid=0. in_ready=1 after reset release. Reset mid-RUN aborts silently; no out_valid.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: mc<=mcand, mp<=mplier, acc<=0, cnt<=0, high_nz<=0, go RUN.
- RUN: in_ready=0. alu_A=acc; alu_B = mp[0] ? mc : 0.
  - Each cycle: acc<=alu_result; mc<=mc<<1; mp<=mp>>1; cnt<=cnt+1.
  - high_nz sets if alu_carry=1, or if mp[0]=1 and the bit shifted out of mc is 1.
  - Leave for DONE when cnt==WIDTH-1 (WIDTH RUN cycles).
- DONE: out_valid=1; product=acc held stable. On out_ready: out_valid<=0, go IDLE. Next operands are accepted no earlier than the following cycle (no IDLE bypass).
- Latency: in_valid accepted at edge 0; out_valid asserts after edge WIDTH+1 (65 cycles at WIDTH=64) without early termination.
- alu_cntrl is driven 3'b010 in every state. alu_A/alu_B are 0 outside RUN.
- The ALU is combinational with gate delays; clock period must exceed the ALU add path. The sequencer registers alu_result only in RUN.
- negative/zero are combinational from product and are valid only while out_valid=1.
- mplier==0 or mcand==0: full iteration count (unless early-term), product=0, zero=1.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined: in RUN, if mp>>1 == 0 after the current add, go to DONE that cycle. Latency becomes (index of highest set mplier bit + 1) RUN cycles, minimum 1. mplier==0 takes 1 RUN cycle.
- high_nz is still exact, because remaining adds are zero.
- Undefined: always WIDTH RUN cycles; latency is fixed and data-independent.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
  - localparam logic [2:0] ALU_PASS_B=3'b000, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_AND=3'b100, ALU_OR=3'b101, ALU_XOR=3'b110.
- Sub-module mul_counter: CNT_W-bit counter with clear/enable and terminal-count output.
- The ALU is instantiated by the testbench/parent, not inside this block.

Test Plan:
- Bench wires a real alu instance to the alu_* ports in all scenarios.
- mcand=3, mplier=5 -> product=15, zero=0, negative=0, high_nz=0; out_valid exactly 65 cycles after handshake (macro off).
- mcand=0xFFFF_FFFF_FFFF_FFFF, mplier=2 -> product=0xFFFF_FFFF_FFFF_FFFE, negative=1, high_nz=1.
- mcand=0x1234, mplier=0 -> product=0, zero=1; with MUL_EARLY_TERM_EN, out_valid after 2 cycles.
- mcand=0x8000_0000_0000_0000, mplier=1 -> product=0x8000_0000_0000_0000, negative=1, high_nz=0; then hold out_ready=0 for 10 cycles -> product and out_valid stable, in_ready=0.
- Assert reset low at RUN cycle 30 -> out_valid=0 and in_ready=1 after release; next op 7*9 -> product=63.
- Back-to-back: two ops with out_ready tied 1 -> second in_valid accepted only in IDLE, the cycle after DONE; products 6*7=42 and 100*100=10000 in order.
